neuron_sched: RTL
=================

NEURON_SCHED -- requirements
Module: neuron_sched

Interface
REQ-001 Parameter: DW_IN, 12, input sample width.
REQ-002 Parameter: DW_OUT, 23, neuron result width.
REQ-003 Parameter: LAT, 4, fixed neuron pipeline latency in cycles (>=1).
REQ-004 Parameter: DEPTH, 4, result buffer entries (power of 2, >=2).
REQ-005 Clock and reset: one clock `clk`; reset `rst` is asynchronous and active-low.
REQ-006 clk  in  1  clock, all logic on rising edge.
REQ-007 rst  in  1  asynchronous active-low reset.
REQ-008 start  in  1  one-cycle frame start request, sampled only in IDLE.
REQ-009 cfg_len  in  8  samples per frame, latched on accepted start.
REQ-010 abort  in  1  synchronous flush, overrides everything except rst.
REQ-011 s_valid  in  1  input sample valid.
REQ-012 s_ready  out  1  scheduler accepts sample this cycle.
REQ-013 s_data  in  DW_IN  input sample.
REQ-014 n_in_data  out  DW_IN  registered drive to neuron in_data.
REQ-015 n_out_data  in  DW_OUT  neuron out_data, valid LAT cycles after n_in_data update.
REQ-016 m_valid  out  1  result available.
REQ-017 m_ready  in  1  downstream accepts result.
REQ-018 m_data  out  DW_OUT  result, head of buffer.
REQ-019 m_last  out  1  qualifies m_data as final result of frame.
REQ-020 busy  out  1  high in RUN or DRAIN.
REQ-021 done  out  1  one-cycle pulse at frame completion.

Function
REQ-022 FSM states IDLE, RUN, DRAIN; IDLE after reset.
REQ-023 IDLE: start=1 with cfg_len!=0 -> RUN next cycle; latch len, clear issue/return counters.
REQ-024 IDLE: start=1 with cfg_len=0 -> done pulses next cycle, stay IDLE.
REQ-025 start outside IDLE ignored; cfg_len changes outside IDLE have no effect.
REQ-026 Issue = s_valid & s_ready; s_ready = (state==RUN) & (issued<len) & (in_flight+fifo_count < DEPTH).
REQ-027 On issue at edge k: n_in_data <= s_data at edge k; tag bit enters LAT-deep valid shift register.
REQ-028 No issue: n_in_data holds previous value; tag entry 0.
REQ-029 Tag exiting shift register at edge k+LAT: n_out_data written into result FIFO at that edge; min sample-to-m_valid latency LAT cycles.
REQ-030 Credit rule: in_flight+fifo_count never exceeds DEPTH; FIFO never overflows, no result dropped.
REQ-031 Same-cycle issue and m-pop: credit count unchanged, both proceed.
REQ-032 Same-cycle FIFO push and pop: both proceed; pop on empty or push on full impossible by construction.
REQ-033 m_valid = FIFO non-empty; m_data/m_last stable while m_valid & !m_ready.
REQ-034 m_last high on result index len-1 (0-based, counted at pop) only.
REQ-035 RUN -> DRAIN at edge where issued reaches len.
REQ-036 DRAIN -> IDLE at edge popping final result (m_valid & m_ready & m_last); done pulses that same next cycle.
REQ-037 len=1 valid: single issue, immediate DRAIN.
REQ-038 Counters 8-bit, no wrap; len=255 supported.
REQ-039 abort=1: next cycle state IDLE, FIFO emptied, tags cleared, counters zero, done not pulsed; in-flight neuron outputs discarded.
REQ-040 abort with start same cycle: abort wins, start dropped.

Reset
REQ-041 rst low: state IDLE, s_ready 0, m_valid 0, m_last 0, m_data 0, n_in_data 0, busy 0, done 0, FIFO pointers/tags/counters 0, asynchronously.
REQ-042 Reset mid-frame discards all buffered and in-flight data; first cycle after release is IDLE.

Verification
REQ-043 Frame len=3, s_valid held, m_ready=1, neuron model = registered pipeline LAT=4: three results in order, m_last on third, done one cycle after third pop.
REQ-044 len=8, m_ready=0: exactly DEPTH=4 issues, then s_ready=0; m_ready=1 -> one credit per pop, all 8 results in order, none lost.
REQ-045 start with cfg_len=0 -> done pulse, busy never high, no s_ready.
REQ-046 abort after 2 of 5 issued, 1 in FIFO -> IDLE next cycle, m_valid 0, later n_out_data ignored, new frame len=2 clean.
REQ-047 rst low mid-DRAIN -> all outputs reset values immediately; start after release runs normal frame.
REQ-048 Random s_valid/m_ready, len=255: scoreboard order matches, occupancy never >DEPTH.

Source files
------------

// File: rtl/neuron_sched_if.sv
// Stream handshake bundle between the neuron scheduler and its source/sink.
// The slave modport is the scheduler's view; the master modport is the environment's view.
interface neuron_sched_if #(
  parameter int unsigned DW_IN  = 12,
  parameter int unsigned DW_OUT = 23
) ();
  logic              s_valid;
  logic              s_ready;
  logic [DW_IN-1:0]  s_data;
  logic              m_valid;
  logic              m_ready;
  logic [DW_OUT-1:0] m_data;
  logic              m_last;

  modport slave (
    input  s_valid, s_data, m_ready,
    output s_ready, m_valid, m_data, m_last
  );

  modport master (
    output s_valid, s_data, m_ready,
    input  s_ready, m_valid, m_data, m_last
  );
endinterface

// File: rtl/neuron_sched.sv
// Frame scheduler for a fixed-latency neuron pipeline. Samples are issued only when a result slot
// is guaranteed, so the result FIFO can never overflow.
module neuron_sched #(
  parameter int unsigned DW_IN  = 12,
  parameter int unsigned DW_OUT = 23,
  parameter int unsigned LAT    = 4,
  parameter int unsigned DEPTH  = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [7:0]         cfg_len,
  input  logic               abort,
  neuron_sched_if.slave      bus,
  output logic [DW_IN-1:0]   n_in_data,
  input  logic [DW_OUT-1:0]  n_out_data,
  output logic               busy,
  output logic               done
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = 16;

  typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

  state_e            r_state, w_state_nxt;
  logic [7:0]        r_len, r_issued, r_popped;
  logic [LAT-1:0]    r_tag;
  logic [DW_OUT-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wr_ptr, r_rd_ptr;
  logic [AW:0]       r_count;
  logic [DW_IN-1:0]  r_n_in;
  logic              r_done, w_done_nxt;
  logic [CW-1:0]     w_in_flight, w_credits;
  logic              w_issue, w_push, w_pop, w_start_ok;

  // Credits cover both in-flight samples and results already buffered.
  always_comb begin
    w_in_flight = '0;
    for (int i = 0; i < LAT; i++) begin
      w_in_flight = w_in_flight + CW'(r_tag[i]);
    end
    w_credits = w_in_flight + CW'(r_count);
  end

  assign bus.s_ready  = (r_state == StRun) && (r_issued < r_len) && (w_credits < CW'(DEPTH));
  assign w_issue      = bus.s_valid & bus.s_ready;
  assign w_push       = r_tag[LAT-1];
  assign bus.m_valid  = (r_count != '0);
  assign w_pop        = bus.m_valid & bus.m_ready;
  assign bus.m_data   = bus.m_valid ? r_mem[r_rd_ptr] : '0;
  assign bus.m_last   = bus.m_valid && (r_popped == r_len - 8'd1);
  assign w_start_ok   = (r_state == StIdle) && start && (cfg_len != 8'd0);
  assign busy         = (r_state != StIdle);
  assign n_in_data    = r_n_in;
  assign done         = r_done;

  always_comb begin
    w_state_nxt = r_state;
    w_done_nxt  = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (start) begin
          if (cfg_len != 8'd0) w_state_nxt = StRun;
          else                 w_done_nxt  = 1'b1;
        end
      end
      StRun: begin
        if (w_issue && (r_issued + 8'd1 == r_len)) w_state_nxt = StDrain;
      end
      StDrain: begin
        if (w_pop && bus.m_last) begin
          w_state_nxt = StIdle;
          w_done_nxt  = 1'b1;
        end
      end
      default: w_state_nxt = StIdle;
    endcase
    if (abort) begin
      w_state_nxt = StIdle;
      w_done_nxt  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= StIdle;
      r_done   <= 1'b0;
      r_len    <= '0;
      r_issued <= '0;
      r_popped <= '0;
      r_tag    <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_n_in   <= '0;
    end else if (abort) begin
      r_state  <= StIdle;
      r_done   <= 1'b0;
      r_len    <= '0;
      r_issued <= '0;
      r_popped <= '0;
      r_tag    <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= w_done_nxt;
      if (w_start_ok) begin
        r_len    <= cfg_len;
        r_issued <= '0;
        r_popped <= '0;
      end else begin
        if (w_issue) r_issued <= r_issued + 8'd1;
        if (w_pop)   r_popped <= r_popped + 8'd1;
      end
      if (w_issue) r_n_in <= bus.s_data;
      r_tag[0] <= w_issue;
      for (int i = 1; i < LAT; i++) begin
        r_tag[i] <= r_tag[i-1];
      end
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= n_out_data;
  end
endmodule
